// File: rtl/wb_defs.sv
// Shared constants and types for the register-file writeback arbiter.
package wb_defs;

  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_DEPTH = 4;

  localparam logic [WB_AW-1:0] WB_REG_ZERO = 5'd0;

  typedef struct packed {
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  function automatic wb_entry_t wb_make_entry(input logic [WB_AW-1:0] rd,
                                              input logic [WB_DW-1:0] data);
    wb_entry_t e;
    e.rd   = rd;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding ALU results ({reg, data}) awaiting the RF write port.
module wb_fifo
  import wb_defs::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int W     = WB_AW + WB_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == {(PW + 1){1'b0}});
  assign count     = r_count;
  assign rdata     = r_mem[r_rptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {(PW + 1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU results and uncancellable load returns onto one RF write port with a WAW scoreboard.
// Optional feature: define WB_ZERO_DROP_EN to make register 0 a read-only zero.
module rf_writeback_arbiter
  import wb_defs::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [AW-1:0]           alu_reg,
  input  logic [DW-1:0]           alu_data,
  input  logic                    ld_issue,
  input  logic [AW-1:0]           ld_issue_reg,
  output logic                    ld_issue_ready,
  input  logic                    ld_valid,
  input  logic [AW-1:0]           ld_reg,
  input  logic [DW-1:0]           ld_data,
  output logic                    write,
  output logic [AW-1:0]           writereg,
  output logic [DW-1:0]           writedata,
  output logic [(1 << AW)-1:0]    busy,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    err
);

  localparam int NREG = 1 << AW;
  localparam int EW   = AW + DW;

  logic            r_write;
  logic [AW-1:0]   r_writereg;
  logic [DW-1:0]   r_writedata;
  logic [NREG-1:0] r_busy;
  logic            r_err;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic            w_alu_accept;
  logic            w_alu_zero;
  logic            w_issue_zero;
  logic            w_ld_zero;
  logic            w_ld_set;
  logic            w_ld_write;
  logic            w_err_set;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_wr_en;
  logic [AW-1:0]   w_wr_reg;
  logic [DW-1:0]   w_wr_data;

`ifdef WB_ZERO_DROP_EN
  assign w_alu_zero   = (alu_reg == {AW{1'b0}});
  assign w_issue_zero = (ld_issue_reg == {AW{1'b0}});
  assign w_ld_zero    = (ld_reg == {AW{1'b0}});
`else
  assign w_alu_zero   = 1'b0;
  assign w_issue_zero = 1'b0;
  assign w_ld_zero    = 1'b0;
`endif

  // Register-0 results are swallowed here, so they never need FIFO space.
  assign alu_ready      = w_alu_zero ? 1'b1 : (!w_full && !r_busy[alu_reg]);
  assign w_alu_accept   = alu_valid && alu_ready;
  assign w_push         = w_alu_accept && !w_alu_zero;
  assign ld_issue_ready = !r_busy[ld_issue_reg];
  assign w_ld_set       = ld_issue && ld_issue_ready && !w_issue_zero;
  assign w_ld_write     = ld_valid && !w_ld_zero;
  assign w_err_set      = w_ld_write && !r_busy[ld_reg];
  assign w_pop          = !w_ld_write && !w_empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .wdata ({alu_reg, alu_data}),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );

  // Scoreboard update: a same-cycle issue to a returning register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREG; i++) begin
      if (w_ld_set && (ld_issue_reg == i[AW-1:0])) begin
        w_busy_nxt[i] = 1'b1;
      end else if (ld_valid && (ld_reg == i[AW-1:0])) begin
        w_busy_nxt[i] = 1'b0;
      end else begin
        w_busy_nxt[i] = r_busy[i];
      end
    end
  end

  // Write-port select: load returns cannot stall, so they preempt the FIFO head.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_reg  = r_writereg;
    w_wr_data = r_writedata;
    if (w_ld_write) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = ld_reg;
      w_wr_data = ld_data;
    end else if (w_pop) begin
      w_wr_en   = 1'b1;
      w_wr_reg  = w_head[EW-1:DW];
      w_wr_data = w_head[DW-1:0];
    end else begin
      w_wr_en   = 1'b0;
    end
  end

  // Registered RF write port, scoreboard and sticky protocol error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write     <= 1'b0;
      r_writereg  <= {AW{1'b0}};
      r_writedata <= {DW{1'b0}};
      r_busy      <= {NREG{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_write     <= w_wr_en;
      r_writereg  <= w_wr_reg;
      r_writedata <= w_wr_data;
      r_busy      <= w_busy_nxt;
      r_err       <= r_err | w_err_set;
    end
  end

  assign write     = r_write;
  assign writereg  = r_writereg;
  assign writedata = r_writedata;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter; expected values are hand-computed per scenario.
module tb_rf_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_reg;
  logic        ld_issue_ready;
  logic        ld_valid;
  logic [4:0]  ld_reg;
  logic [31:0] ld_data;
  logic        write;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic [31:0] busy;
  logic [2:0]  fifo_count;
  logic        err;

  int n_total;
  int n_bad;

  rf_writeback_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_reg        (alu_reg),
    .alu_data       (alu_data),
    .ld_issue       (ld_issue),
    .ld_issue_reg   (ld_issue_reg),
    .ld_issue_ready (ld_issue_ready),
    .ld_valid       (ld_valid),
    .ld_reg         (ld_reg),
    .ld_data        (ld_data),
    .write          (write),
    .writereg       (writereg),
    .writedata      (writedata),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] r, input logic [31:0] d);
    check_val({tag, ".write"}, 64'(write), 64'd1);
    check_val({tag, ".reg"}, 64'(writereg), 64'(r));
    check_val({tag, ".data"}, 64'(writedata), 64'(d));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    ld_issue = 1'b0; ld_issue_reg = 5'd0;
    ld_valid = 1'b0; ld_reg = 5'd0; ld_data = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_val("rst.write", 64'(write), 64'd0);
    check_val("rst.writereg", 64'(writereg), 64'd0);
    check_val("rst.writedata", 64'(writedata), 64'd0);
    check_val("rst.busy", 64'(busy), 64'd0);
    check_val("rst.count", 64'(fifo_count), 64'd0);
    check_val("rst.err", 64'(err), 64'd0);
    check_val("rst.alu_ready", 64'(alu_ready), 64'd1);

    // 1: ALU write appears two cycles after acceptance
    alu_valid = 1'b1; alu_reg = 5'd5; alu_data = 32'h11;
    #1;
    check_val("t1.ready", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_val("t1.push_nowrite", 64'(write), 64'd0);
    check_val("t1.count1", 64'(fifo_count), 64'd1);
    tick();
    check_write("t1", 5'd5, 32'h11);
    check_val("t1.count0", 64'(fifo_count), 64'd0);
    tick();
    check_val("t1.idle_write", 64'(write), 64'd0);
    check_val("t1.hold_reg", 64'(writereg), 64'd5);
    check_val("t1.hold_data", 64'(writedata), 64'h11);

    // 2: load return preempts a queued ALU result
    alu_valid = 1'b1; alu_reg = 5'd3; alu_data = 32'hA;
    ld_issue = 1'b1; ld_issue_reg = 5'd7;
    tick();
    alu_valid = 1'b0; ld_issue = 1'b0;
    check_val("t2.busy7", 64'(busy[7]), 64'd1);
    ld_valid = 1'b1; ld_reg = 5'd7; ld_data = 32'hB;
    tick();
    ld_valid = 1'b0;
    check_write("t2.ld", 5'd7, 32'hB);
    check_val("t2.count_held", 64'(fifo_count), 64'd1);
    tick();
    check_write("t2.alu", 5'd3, 32'hA);
    check_val("t2.err", 64'(err), 64'd0);

    // 3: WAW guard holds an ALU result behind the pending load
    ld_issue = 1'b1; ld_issue_reg = 5'd9;
    #1;
    check_val("t3.issue_ready", 64'(ld_issue_ready), 64'd1);
    tick();
    ld_issue = 1'b0;
    check_val("t3.busy9_set", 64'(busy[9]), 64'd1);
    check_val("t3.issue_blocked", 64'(ld_issue_ready), 64'd0);
    alu_valid = 1'b1; alu_reg = 5'd9; alu_data = 32'h99;
    #1;
    check_val("t3.alu_blocked", 64'(alu_ready), 64'd0);
    tick();
    tick();
    check_val("t3.still_blocked", 64'(alu_ready), 64'd0);
    check_val("t3.no_push", 64'(fifo_count), 64'd0);
    ld_valid = 1'b1; ld_reg = 5'd9; ld_data = 32'h55;
    tick();
    ld_valid = 1'b0;
    check_write("t3.ld", 5'd9, 32'h55);
    check_val("t3.busy9_clr", 64'(busy[9]), 64'd0);
    check_val("t3.alu_unblocked", 64'(alu_ready), 64'd1);
    tick();
    alu_valid = 1'b0;
    check_val("t3.gap", 64'(write), 64'd0);
    tick();
    check_write("t3.alu", 5'd9, 32'h99);

    // 4: fill the FIFO while load returns block every pop
    for (int k = 0; k < 4; k++) begin
      ld_issue = 1'b1; ld_issue_reg = 5'(20 + k);
      tick();
    end
    ld_issue = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_reg = 5'(10 + k); alu_data = 32'hA0 + 32'(k);
      ld_valid = 1'b1; ld_reg = 5'(20 + k); ld_data = 32'h200 + 32'(k);
      tick();
    end
    check_write("t4.last_ld", 5'd23, 32'h203);
    ld_valid = 1'b0;
    alu_reg = 5'd15; alu_data = 32'hF5;
    #1;
    check_val("t4.count_full", 64'(fifo_count), 64'd4);
    check_val("t4.full_ready", 64'(alu_ready), 64'd0);
    tick();
    check_write("t4.e0", 5'd10, 32'hA0);
    check_val("t4.count3", 64'(fifo_count), 64'd3);
    check_val("t4.ready_again", 64'(alu_ready), 64'd1);
    alu_valid = 1'b0;
    tick();
    check_write("t4.e1", 5'd11, 32'hA1);
    tick();
    check_write("t4.e2", 5'd12, 32'hA2);
    tick();
    check_write("t4.e3", 5'd13, 32'hA3);
    check_val("t4.empty", 64'(fifo_count), 64'd0);
    tick();
    check_val("t4.drained", 64'(write), 64'd0);

    // 5: load return to a non-busy register still writes and flags err
    ld_valid = 1'b1; ld_reg = 5'd12; ld_data = 32'hC12;
    tick();
    ld_valid = 1'b0;
    check_write("t5", 5'd12, 32'hC12);
    check_val("t5.err_set", 64'(err), 64'd1);
    tick();
    tick();
    check_val("t5.err_sticky", 64'(err), 64'd1);

    // 6: reset drops queued results and pending loads
    ld_issue = 1'b1; ld_issue_reg = 5'd2;
    tick();
    for (int k = 0; k < 3; k++) begin
      ld_issue_reg = 5'(16 + k);
      tick();
    end
    ld_issue = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_reg = 5'(24 + k); alu_data = 32'hE0 + 32'(k);
      ld_valid = 1'b1; ld_reg = 5'(16 + k); ld_data = 32'h300 + 32'(k);
      tick();
    end
    alu_valid = 1'b0; ld_valid = 1'b0;
    check_val("t6.count3", 64'(fifo_count), 64'd3);
    check_val("t6.busy2", 64'(busy[2]), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6.write", 64'(write), 64'd0);
    check_val("t6.writereg", 64'(writereg), 64'd0);
    check_val("t6.writedata", 64'(writedata), 64'd0);
    check_val("t6.busy", 64'(busy), 64'd0);
    check_val("t6.count", 64'(fifo_count), 64'd0);
    check_val("t6.err", 64'(err), 64'd0);
    ld_issue_reg = 5'd2;
    #1;
    check_val("t6.issue_ready2", 64'(ld_issue_ready), 64'd1);
    tick();
    tick();
    tick();
    check_val("t6.no_stale_write", 64'(write), 64'd0);

    // Register 0 handling depends on build configuration
    alu_valid = 1'b1; alu_reg = 5'd0; alu_data = 32'h77;
    tick();
    alu_valid = 1'b0;
`ifdef WB_ZERO_DROP_EN
    check_val("z.count", 64'(fifo_count), 64'd0);
    tick();
    check_val("z.no_write", 64'(write), 64'd0);
`else
    check_val("z.count", 64'(fifo_count), 64'd1);
    tick();
    check_write("z", 5'd0, 32'h77);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
